hc04_ranger: RTL and testbench

//   Synthesizable initiator for one HC-SR04 ultrasonic ranger.
//   - On request, drives the trigger pulse and times the returned echo

---
 rtl/hc04_pkg.sv | 22 ++
 rtl/hc04_ranger_if.sv | 13 +
 rtl/us_ticker.sv | 25 ++
 rtl/hc04_ranger.sv | 143 ++++++++++++++
 tb/tb_hc04_ranger.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hc04_pkg.sv
// Shared definitions for the HC-SR04 ranger: state encoding and default timing.
package hc04_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam int DEF_CLK_MHZ    = 50;
  localparam int DEF_TRIG_US    = 12;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_HOLDOFF_US = 60000;
  localparam int DEF_W          = 16;

  // Sensor-side figures, used by the echo model that drives the ranger.
  localparam int SENSOR_TRIG_MIN_US = 10;
  localparam int ECHO_DELAY_NS      = 1000;

endpackage

// File: rtl/hc04_ranger_if.sv
// Request/result handshake between the sensor scheduler and one ranger.
interface hc04_ranger_if #(
  parameter int W = 16
) ();
  logic         start;
  logic         busy;
  logic [W-1:0] result_us;
  logic         result_valid;
  logic         timeout;

  modport master (output start, input busy, result_us, result_valid, timeout);
  modport slave  (input start, output busy, result_us, result_valid, timeout);
endinterface

// File: rtl/us_ticker.sv
// Microsecond prescaler: free-runs 0..CLK_MHZ-1 and pulses us_tick on the wrap.
module us_ticker #(
  parameter int CLK_MHZ = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic us_tick
);
  localparam int CW = $clog2(CLK_MHZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_MHZ - 1);

  logic [CW-1:0] cnt;

  // clear lands one clk after the state change; that clk already belongs to the
  // new phase, hence the reload to 1 rather than 0.
  assign us_tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clear)       cnt <= CW'(1);
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/hc04_ranger.sv
// HC-SR04 initiator: fires the trigger pulse on request and times the echo in us,
// reporting a width or a timeout, then enforces the sensor's re-trigger holdoff.
module hc04_ranger
  import hc04_pkg::*;
#(
  parameter int CLK_MHZ    = DEF_CLK_MHZ,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US = DEF_HOLDOFF_US,
  parameter int W          = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  hc04_ranger_if.slave bus,
  output logic         hc04_trigger,
  input  logic         hc04_echo
);
  localparam int TW = W + 1;
  localparam logic [W-1:0]  TRIG_N    = W'(TRIG_US);
  localparam logic [W-1:0]  TIMEOUT_N = W'(TIMEOUT_US);
  localparam logic [TW-1:0] HOLD_N    = TW'(HOLDOFF_US);

  state_t        state;
  logic [2:0]    echo_sync;
  logic          echo_s, echo_rise, echo_fall;
  logic          phase_restart, us_tick;
  logic [W-1:0]  us_cnt, us_now;
  logic [TW-1:0] tot_us;
  logic          busy_q, valid_q, timeout_q;
  logic [W-1:0]  result_q;

  us_ticker #(.CLK_MHZ(CLK_MHZ)) u_ticker (
    .clk     (clk),
    .rst     (rst),
    .clear   (phase_restart),
    .us_tick (us_tick)
  );

  // [1:0] is the synchronizer, [2] the previous synchronized value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so each stage takes its neighbour's pre-edge value;
    // blocking here would collapse the chain into a single flop.
    if (rst) echo_sync <= '0;
    else     echo_sync <= {echo_sync[1:0], hc04_echo};
  end

  assign echo_s    = echo_sync[1];
  assign echo_rise = echo_sync[1] & ~echo_sync[2];
  assign echo_fall = ~echo_sync[1] & echo_sync[2];

  // Counter value as of this edge, so "reaches N" and a coinciding fall agree.
  assign us_now = (us_tick && us_cnt != '1) ? us_cnt + W'(1) : us_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hc04_trigger  <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= '0;
      phase_restart <= 1'b0;
      us_cnt        <= '0;
      tot_us        <= '0;
    end else begin
      valid_q       <= 1'b0;
      phase_restart <= 1'b0;
      if (us_tick && us_cnt != '1) us_cnt <= us_cnt + W'(1);
      if (us_tick && tot_us != '1) tot_us <= tot_us + TW'(1);

      unique case (state)
        IDLE: if (bus.start) begin
          busy_q        <= 1'b1;
          phase_restart <= 1'b1;
          us_cnt        <= '0;
          tot_us        <= '0;
          if (echo_s) begin
            // Echo already high before triggering: the sensor is stuck.
            state     <= HOLDOFF;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            result_q  <= '0;
          end else begin
            state        <= TRIG;
            hc04_trigger <= 1'b1;
          end
        end

        TRIG: if (us_now == TRIG_N) begin
          hc04_trigger  <= 1'b0;
          state         <= WAIT_RISE;
          phase_restart <= 1'b1;
          us_cnt        <= '0;
        end

        WAIT_RISE: begin
          if (echo_rise) begin
            state         <= MEASURE;
            phase_restart <= 1'b1;
            us_cnt        <= '0;
          end else if (us_now == TIMEOUT_N) begin
            state         <= HOLDOFF;
            phase_restart <= 1'b1;
            us_cnt        <= '0;
            valid_q       <= 1'b1;
            timeout_q     <= 1'b1;
            result_q      <= '0;
          end
        end

        MEASURE: begin
          if (echo_fall) begin
            state         <= HOLDOFF;
            phase_restart <= 1'b1;
            us_cnt        <= '0;
            valid_q       <= 1'b1;
            timeout_q     <= 1'b0;
            result_q      <= us_now;
          end else if (us_now == TIMEOUT_N) begin
            state         <= HOLDOFF;
            phase_restart <= 1'b1;
            us_cnt        <= '0;
            valid_q       <= 1'b1;
            timeout_q     <= 1'b1;
            result_q      <= TIMEOUT_N;
          end
        end

        HOLDOFF: if (tot_us >= HOLD_N) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_us    = result_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_hc04_ranger.sv
// Directed bench for hc04_ranger with a behavioural HC-SR04 echo model.
// Timing is scaled (2 MHz clock, 1 ms timeout, 2 ms holdoff) to keep runs short.
module tb_hc04_ranger;
  import hc04_pkg::*;

  localparam int CLK_MHZ     = 2;
  localparam int TRIG_US     = DEF_TRIG_US;
  localparam int TIMEOUT_US  = 1000;
  localparam int HOLDOFF_US  = 2000;
  localparam int W           = DEF_W;
  localparam int HALF        = 500 / CLK_MHZ;   // time unit taken as 1 ns
  localparam int RES_BUDGET  = (TRIG_US + TIMEOUT_US + 20) * CLK_MHZ;
  localparam int IDLE_BUDGET = (HOLDOFF_US + 20) * CLK_MHZ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic echo_model = 1'b0;
  logic echo_force = 1'b0;
  logic hc04_trigger;
  logic hc04_echo;

  assign hc04_echo = echo_model | echo_force;

  hc04_ranger_if #(.W(W)) bus ();

  hc04_ranger #(
    .CLK_MHZ    (CLK_MHZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .HOLDOFF_US (HOLDOFF_US),
    .W          (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .hc04_trigger (hc04_trigger),
    .hc04_echo    (hc04_echo)
  );

  always #HALF clk = ~clk;

  int      vectors = 0;
  int      miscompares = 0;
  int      rv_count = 0;
  int      trig_rises = 0;
  int      short_trig = 0;
  int      echo_width_us = 0;
  realtime trig_rise_t = 0.0;
  realtime trig_fall_t = 0.0;
  realtime trig_width = 0.0;

  always @(negedge clk) if (bus.result_valid === 1'b1) rv_count++;

  always @(posedge hc04_trigger) begin
    trig_rise_t = $realtime;
    trig_rises++;
  end

  // Echo model: echo rises ECHO_DELAY_NS after trigger falls (nudged off the clock edge).
  always @(negedge hc04_trigger) begin
    if (!rst) begin
      trig_fall_t = $realtime;
      trig_width  = trig_fall_t - trig_rise_t;
      if (trig_width < SENSOR_TRIG_MIN_US * 1000) short_trig++;
      if (echo_width_us > 0) begin
        #(ECHO_DELAY_NS + 1);
        echo_model = 1'b1;
        #(echo_width_us * 1000);
        echo_model = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_range(input string tag, input int observed, input int lo, input int hi);
    vectors++;
    assert (observed >= lo && observed <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int budget,
                             output logic [W-1:0] res, output logic tmo);
    int n = 0;
    while (bus.result_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " result_valid seen"}, 32'(bus.result_valid), 32'd1);
    res = bus.result_us;
    tmo = bus.timeout;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " back to idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_echo(input string tag, input logic level, input int budget);
    int n = 0;
    while (hc04_echo !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(hc04_echo), 32'(level));
  endtask

  initial begin
    logic [W-1:0] res;
    logic         tmo;
    int           rv0, tr0;
    realtime      t_first;

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset trigger",      32'(hc04_trigger),     32'd0);
    check("reset busy",         32'(bus.busy),         32'd0);
    check("reset result_us",    32'(bus.result_us),    32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset timeout",      32'(bus.timeout),      32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: normal 580 us echo
    echo_width_us = 580;
    rv0 = rv_count;
    do_start();
    check("t1 busy after start", 32'(bus.busy), 32'd1);
    wait_result("t1", RES_BUDGET, res, tmo);
    check_range("t1 result_us", int'(res), 579, 581);
    check("t1 timeout", 32'(tmo), 32'd0);
    check_range("t1 trigger width", int'(trig_width), TRIG_US * 1000 - 2 * HALF, TRIG_US * 1000 + 2 * HALF);
    wait_idle("t1", IDLE_BUDGET);
    check("t1 result count", rv_count - rv0, 1);

    // 2: no echo at all
    echo_width_us = 0;
    rv0 = rv_count;
    do_start();
    wait_result("t2", RES_BUDGET, res, tmo);
    check_range("t2 fall-to-result ns", int'($realtime - trig_fall_t),
                TIMEOUT_US * 1000 - 1000, TIMEOUT_US * 1000 + 1000);
    check("t2 timeout", 32'(tmo), 32'd1);
    check("t2 result_us", 32'(res), 32'd0);
    wait_idle("t2", IDLE_BUDGET);
    check("t2 result count", rv_count - rv0, 1);

    // 3: echo longer than the timeout, then a start during holdoff
    echo_width_us = 1400;
    rv0 = rv_count;
    tr0 = trig_rises;
    do_start();
    wait_result("t3", RES_BUDGET, res, tmo);
    check("t3 result_us", 32'(res), 32'(TIMEOUT_US));
    check("t3 timeout", 32'(tmo), 32'd1);
    do_start();
    check("t3 busy during holdoff", 32'(bus.busy), 32'd1);
    wait_idle("t3", IDLE_BUDGET);
    repeat (10) @(negedge clk);
    check("t3 holdoff start ignored", 32'(bus.busy), 32'd0);
    check("t3 trigger count", trig_rises - tr0, 1);
    check("t3 result count", rv_count - rv0, 1);

    // 4: back-to-back requests, 100 us echo
    echo_width_us = 100;
    rv0 = rv_count;
    do_start();
    t_first = trig_rise_t;
    wait_result("t4a", RES_BUDGET, res, tmo);
    check_range("t4a result_us", int'(res), 99, 101);
    wait_idle("t4a", IDLE_BUDGET);
    do_start();
    check_range("t4 trigger spacing ns", int'(trig_rise_t - t_first), HOLDOFF_US * 1000, 32'h7fff_ffff);
    wait_result("t4b", RES_BUDGET, res, tmo);
    check_range("t4b result_us", int'(res), 99, 101);
    check("t4b timeout", 32'(tmo), 32'd0);
    wait_idle("t4b", IDLE_BUDGET);
    check("t4 result count", rv_count - rv0, 2);

    // 5: reset in the middle of a measurement
    echo_width_us = 200;
    rv0 = rv_count;
    do_start();
    wait_echo("t5 echo rose", 1'b1, RES_BUDGET);
    #50000;
    rst = 1'b1;
    #10;
    check("t5 reset trigger",      32'(hc04_trigger),     32'd0);
    check("t5 reset busy",         32'(bus.busy),         32'd0);
    check("t5 reset result_valid", 32'(bus.result_valid), 32'd0);
    check("t5 reset result_us",    32'(bus.result_us),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_echo("t5 echo fell", 1'b0, 400 * CLK_MHZ);
    repeat (10) @(negedge clk);
    check("t5 no result after reset", rv_count - rv0, 0);
    do_start();
    wait_result("t5", RES_BUDGET, res, tmo);
    check_range("t5 result_us", int'(res), 199, 201);
    check("t5 timeout", 32'(tmo), 32'd0);
    wait_idle("t5", IDLE_BUDGET);

    // 6: echo already high when start arrives
    echo_width_us = 0;
    echo_force = 1'b1;
    repeat (5) @(negedge clk);
    rv0 = rv_count;
    tr0 = trig_rises;
    do_start();
    wait_result("t6", 4, res, tmo);
    check("t6 timeout", 32'(tmo), 32'd1);
    check("t6 result_us", 32'(res), 32'd0);
    wait_idle("t6", IDLE_BUDGET);
    echo_force = 1'b0;
    check("t6 trigger never pulsed", trig_rises - tr0, 0);
    check("t6 result count", rv_count - rv0, 1);
    check("short trigger pulses", short_trig, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
